// File: rtl/glyph_pixel_engine_pkg.sv
// glyph_pkg: shared constants for the text-mode glyph pixel engine.
//   - Glyph code assignments (SPACE, A..Z, 0..9, arrows) for the 64-glyph set.
//   - Bit positions of the PicoBlaze-written control register.
//   - ctrl_t: unpacked view of the control register.
//   - LAT: fixed Qh/Qv-to-pixel latency in clocks.
package glyph_pkg;

    localparam int LAT = 4;

    localparam int CTRL_ALARM = 0;
    localparam int CTRL_BLINK = 1;
    localparam int CTRL_INV   = 2;

    typedef struct packed {
        logic inverse;
        logic blink_en;
        logic alarm;
    } ctrl_t;

    localparam logic [5:0] G_SPACE = 6'd0;
    localparam logic [5:0] G_A = 6'd1,  G_B = 6'd2,  G_C = 6'd3,  G_D = 6'd4,  G_E = 6'd5;
    localparam logic [5:0] G_F = 6'd6,  G_G = 6'd7,  G_H = 6'd8,  G_I = 6'd9,  G_J = 6'd10;
    localparam logic [5:0] G_K = 6'd11, G_L = 6'd12, G_M = 6'd13, G_N = 6'd14, G_O = 6'd15;
    localparam logic [5:0] G_P = 6'd16, G_Q = 6'd17, G_R = 6'd18, G_S = 6'd19, G_T = 6'd20;
    localparam logic [5:0] G_U = 6'd21, G_V = 6'd22, G_W = 6'd23, G_X = 6'd24, G_Y = 6'd25;
    localparam logic [5:0] G_Z = 6'd26;
    localparam logic [5:0] G_0 = 6'd27, G_1 = 6'd28, G_2 = 6'd29, G_3 = 6'd30, G_4 = 6'd31;
    localparam logic [5:0] G_5 = 6'd32, G_6 = 6'd33, G_7 = 6'd34, G_8 = 6'd35, G_9 = 6'd36;
    localparam logic [5:0] G_UP = 6'd37, G_DOWN = 6'd38, G_LEFT = 6'd39, G_RIGHT = 6'd40;

endpackage

// File: rtl/glyph_pixel_engine_rom.sv
// glyph_rom: synchronous glyph ROM, one clock latency.
//   clk      in   clock
//   rst      in   asynchronous reset, active high (clears the output register)
//   addr     in   {code, row}
//   row_bits out  GLYPH_W-bit glyph row, MSB is the leftmost pixel
// The font is stored as 8x8 bitmaps; 16-pixel glyph sizes stretch each stored
// row/column by two. Codes without a bitmap return an all-zero row (space).
module glyph_rom
    import glyph_pkg::*;
#(
    parameter int GLYPH_W = 8,
    parameter int GLYPH_H = 8,
    parameter int CODE_W  = 6
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [CODE_W+$clog2(GLYPH_H)-1:0] addr,
    output logic [GLYPH_W-1:0]                row_bits
);

    localparam int RB = $clog2(GLYPH_H);
    localparam int YS = RB - 3;
    localparam int XS = $clog2(GLYPH_W) - 3;

    function automatic logic [63:0] font8(input logic [5:0] code);
        case (code)
            G_A:     font8 = 64'h183C667E66666600;
            G_B:     font8 = 64'h7C66667C66667C00;
            G_0:     font8 = 64'h3C666E7666663C00;
            G_1:     font8 = 64'h1838181818187E00;
            G_UP:    font8 = 64'h183C7E1818181800;
            G_DOWN:  font8 = 64'h181818187E3C1800;
            default: font8 = 64'h0;
        endcase
    endfunction

    logic [31:0]        code32;
    logic [RB-1:0]      row;
    logic [2:0]         row8;
    logic [63:0]        bitmap;
    logic [7:0]         bits8;
    logic [GLYPH_W-1:0] wide;

    assign code32 = 32'(addr[RB +: CODE_W]);
    assign row    = addr[RB-1:0];

    // Pick the stored 8-pixel row; codes outside the 64-entry font are blank.
    // Row 0 sits in the top byte, so the byte offset is the inverted row.
    always_comb begin
        row8   = 3'(row >> YS);
        bitmap = (code32[31:6] == '0) ? font8(code32[5:0]) : 64'h0;
        bits8  = bitmap[{~row8, 3'b000} +: 8];
    end

    for (genvar i = 0; i < GLYPH_W; i++) begin : g_widen
        assign wide[i] = bits8[i >> XS];
    end

    // Output register gives the one-clock read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) row_bits <= '0;
        else     row_bits <= wide;
    end

endmodule

// File: rtl/glyph_pixel_engine.sv
// glyph_pixel_engine: text-mode pixel generator between sync generator and RGB mux.
//   reloj        in   pixel clock
//   resetM       in   asynchronous reset, active high
//   Qh, Qv       in   scan position
//   port_id, out_port, write_strobe  in  PicoBlaze control register write
//   char_addr    out  text RAM address (row*COLS + col), held outside the active area
//   char_code    in   text RAM data, one clock after char_addr
//   pixel_on     out  glyph pixel, 4 clocks after its Qh/Qv
//   pixel_valid  out  pixel_on belongs to a complete character cell
module glyph_pixel_engine
    import glyph_pkg::*;
#(
    parameter int         GLYPH_W      = 8,
    parameter int         GLYPH_H      = 8,
    parameter int         SCALE_LOG2   = 0,
    parameter int         H_ACTIVE     = 640,
    parameter int         V_ACTIVE     = 480,
    parameter int         CODE_W       = 6,
    parameter int         BLINK_FRAMES = 30,
    parameter logic [7:0] CTRL_PORT    = 8'h00
) (
    input  logic              reloj,
    input  logic              resetM,
    input  logic [9:0]        Qh,
    input  logic [9:0]        Qv,
    input  logic [7:0]        port_id,
    input  logic [7:0]        out_port,
    input  logic              write_strobe,
    output logic [11:0]       char_addr,
    input  logic [CODE_W-1:0] char_code,
    output logic              pixel_on,
    output logic              pixel_valid
);

    localparam int CELL_W = GLYPH_W << SCALE_LOG2;
    localparam int CELL_H = GLYPH_H << SCALE_LOG2;
    localparam int COLS   = H_ACTIVE / CELL_W;
    localparam int ROWS   = V_ACTIVE / CELL_H;
    localparam int XB     = $clog2(GLYPH_W);
    localparam int YB     = $clog2(GLYPH_H);
    localparam int FC_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    // Only whole cells count as active; partial edge cells fall outside.
    localparam logic [9:0] X_LIM = 10'(COLS * CELL_W);
    localparam logic [9:0] Y_LIM = 10'(ROWS * CELL_H);

    logic [9:0]         cell_col, cell_row;
    logic [11:0]        addr_next;
    logic               in_area;
    logic [XB-1:0]      col_off, col_off1, col_off2, col_off3;
    logic [YB-1:0]      row_off, row_off1, row_off2;
    logic               in_area1, in_area2, in_area3;
    logic [GLYPH_W-1:0] glyph_row;
    logic               glyph_bit;
    ctrl_t              ctrl;
    logic [FC_W-1:0]    frame_cnt;
    logic               blink_phase;
    logic               frame_tick;
    logic               unused_bits;

    assign unused_bits = ^out_port[7:3];
    assign frame_tick  = (Qh == 10'd0) && (Qv == 10'd0);

    // Cell coordinates and in-cell offsets of the current scan position.
    always_comb begin
        cell_col  = Qh >> (XB + SCALE_LOG2);
        cell_row  = Qv >> (YB + SCALE_LOG2);
        in_area   = (Qh < X_LIM) && (Qv < Y_LIM);
        addr_next = 12'(cell_row * COLS + cell_col);
        col_off   = XB'(Qh >> SCALE_LOG2);
        row_off   = YB'(Qv >> SCALE_LOG2);
    end

    // E1..E3 delay line; E2 is the text RAM read, so row_off2 lines up
    // with char_code when both address the glyph ROM.
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            char_addr <= '0;
            col_off1  <= '0;
            row_off1  <= '0;
            in_area1  <= 1'b0;
            col_off2  <= '0;
            row_off2  <= '0;
            in_area2  <= 1'b0;
            col_off3  <= '0;
            in_area3  <= 1'b0;
        end else begin
            if (in_area) char_addr <= addr_next;
            col_off1 <= col_off;
            row_off1 <= row_off;
            in_area1 <= in_area;
            col_off2 <= col_off1;
            row_off2 <= row_off1;
            in_area2 <= in_area1;
            col_off3 <= col_off2;
            in_area3 <= in_area2;
        end
    end

    glyph_rom #(
        .GLYPH_W (GLYPH_W),
        .GLYPH_H (GLYPH_H),
        .CODE_W  (CODE_W)
    ) u_rom (
        .clk      (reloj),
        .rst      (resetM),
        .addr     ({char_code, row_off2}),
        .row_bits (glyph_row)
    );

    // Leftmost pixel is the MSB; for a power-of-two width GLYPH_W-1-col is ~col.
    assign glyph_bit = glyph_row[~col_off3];

    // Control register, written from the PicoBlaze output port.
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            ctrl <= '0;
        end else if (write_strobe && (port_id == CTRL_PORT)) begin
            ctrl <= '{inverse:  out_port[CTRL_INV],
                      blink_en: out_port[CTRL_BLINK],
                      alarm:    out_port[CTRL_ALARM]};
        end
    end

    // Frame counter; blink_phase flips each time it wraps.
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_tick) begin
            if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // E4: mode priority, highest first.
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            pixel_on    <= 1'b0;
            pixel_valid <= 1'b0;
        end else if (!in_area3) begin
            pixel_on    <= 1'b0;
            pixel_valid <= 1'b0;
        end else if (ctrl.alarm && (!ctrl.blink_en || blink_phase)) begin
            pixel_on    <= 1'b0;
            pixel_valid <= 1'b1;
        end else begin
            pixel_on    <= glyph_bit ^ ctrl.inverse;
            pixel_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_glyph_pixel_engine.sv
// tb_glyph_pixel_engine: two engine instances driven by the same scan/control
// stimulus: dut_a (defaults, BLINK_FRAMES=2) and dut_b (SCALE_LOG2=1). Each has
// its own synchronous text RAM model over a shared character memory.
module tb_glyph_pixel_engine;
    import glyph_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] qh = 10'd700;
    logic [9:0] qv = 10'd500;
    logic [7:0] port_id = 8'h00;
    logic [7:0] out_port = 8'h00;
    logic       ws = 1'b0;

    logic [11:0] addr_a, addr_b;
    logic [5:0]  code_a = '0;
    logic [5:0]  code_b = '0;
    logic        on_a, valid_a, on_b, valid_b;

    logic [5:0] mem [0:4095];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    glyph_pixel_engine #(.BLINK_FRAMES(2)) dut_a (
        .reloj(clk), .resetM(rst), .Qh(qh), .Qv(qv),
        .port_id(port_id), .out_port(out_port), .write_strobe(ws),
        .char_addr(addr_a), .char_code(code_a),
        .pixel_on(on_a), .pixel_valid(valid_a)
    );

    glyph_pixel_engine #(.SCALE_LOG2(1)) dut_b (
        .reloj(clk), .resetM(rst), .Qh(qh), .Qv(qv),
        .port_id(port_id), .out_port(out_port), .write_strobe(ws),
        .char_addr(addr_b), .char_code(code_b),
        .pixel_on(on_b), .pixel_valid(valid_b)
    );

    // Synchronous text RAMs: data one clock after the address.
    always @(posedge clk) begin
        code_a <= mem[addr_a];
        code_b <= mem[addr_b];
    end

    function automatic logic [7:0] font_row(input int code, input int row);
        logic [7:0] g [8];
        case (code)
            1:       g = '{8'h18, 8'h3C, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h66, 8'h00};
            2:       g = '{8'h7C, 8'h66, 8'h66, 8'h7C, 8'h66, 8'h66, 8'h7C, 8'h00};
            27:      g = '{8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00};
            28:      g = '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00};
            37:      g = '{8'h18, 8'h3C, 8'h7E, 8'h18, 8'h18, 8'h18, 8'h18, 8'h00};
            38:      g = '{8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h3C, 8'h18, 8'h00};
            default: g = '{default: 8'h00};
        endcase
        return g[row];
    endfunction

    // Text RAM address of a scan position, or -1 outside the whole-cell area.
    function automatic int model_addr(input int scale, input int x, input int y);
        int cw, cols, rows;
        cw   = 8 << scale;
        cols = 640 / cw;
        rows = 480 / cw;
        if (x >= cols * cw || y >= rows * cw) return -1;
        return (y / cw) * cols + x / cw;
    endfunction

    // Pixel a scan position should produce given the control bits and the
    // number of frame ticks seen since reset.
    function automatic void model_pixel(input int scale, input int bf, input int x, input int y,
                                        input logic [2:0] c, input int ticks,
                                        output logic on, output logic valid);
        int a;
        logic [7:0] bits;
        logic b, phase;
        a = model_addr(scale, x, y);
        if (a < 0) begin
            on = 1'b0;
            valid = 1'b0;
            return;
        end
        valid = 1'b1;
        bits  = font_row(int'(mem[a]), (y >> scale) % 8);
        b     = bits[7 - ((x >> scale) % 8)];
        phase = ((ticks / bf) % 2) == 1;
        if (c[0] && !c[1])          on = 1'b0;
        else if (c[0] && c[1] && phase) on = 1'b0;
        else                        on = b ^ c[2];
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int x, input int y, input logic w,
                                 input logic [7:0] pid, input logic [7:0] data);
        @(posedge clk);
        #1;
        qh       = 10'(x);
        qv       = 10'(y);
        ws       = w;
        port_id  = pid;
        out_port = data;
    endtask

    task automatic scanLine(input int y, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) applyStimulus(x, y, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) applyStimulus(640, 0, 1'b0, 8'h00, 8'h00);
    endtask

    // Model state: input history of the last four edges, control register,
    // frame tick count and last in-area address per instance.
    int          hq [4];
    int          hv [4];
    bit          hr [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    logic [2:0]  ctrl_m = 3'b000;
    int          ticks_m = 0;
    int          addr_m [2] = '{0, 0};
    logic        exp_on [2] = '{1'b0, 1'b0};
    logic        exp_valid [2] = '{1'b0, 1'b0};
    int          scale_of [2] = '{0, 1};
    int          bf_of [2] = '{2, 30};

    initial begin
        forever begin
            @(posedge clk);
            for (int i = 3; i > 0; i--) begin
                hq[i] = hq[i-1];
                hv[i] = hv[i-1];
                hr[i] = hr[i-1];
            end
            hq[0] = int'(qh);
            hv[0] = int'(qv);
            hr[0] = rst;
            if (rst) begin
                ctrl_m  = 3'b000;
                ticks_m = 0;
                for (int d = 0; d < 2; d++) begin
                    addr_m[d]    = 0;
                    exp_on[d]    = 1'b0;
                    exp_valid[d] = 1'b0;
                end
            end else begin
                for (int d = 0; d < 2; d++) begin
                    int a;
                    if (hr[1] || hr[2] || hr[3]) begin
                        exp_on[d]    = 1'b0;
                        exp_valid[d] = 1'b0;
                    end else begin
                        model_pixel(scale_of[d], bf_of[d], hq[3], hv[3], ctrl_m, ticks_m,
                                    exp_on[d], exp_valid[d]);
                    end
                    a = model_addr(scale_of[d], hq[0], hv[0]);
                    if (a >= 0) addr_m[d] = a;
                end
                if (ws && port_id == 8'h00) ctrl_m = out_port[2:0];
                if (hq[0] == 0 && hv[0] == 0) ticks_m++;
            end
            @(negedge clk);
            if (rst) begin
                checkOutput("a_addr_rst", int'(addr_a), 0);
                checkOutput("a_on_rst", int'(on_a), 0);
                checkOutput("a_valid_rst", int'(valid_a), 0);
                checkOutput("b_addr_rst", int'(addr_b), 0);
                checkOutput("b_on_rst", int'(on_b), 0);
                checkOutput("b_valid_rst", int'(valid_b), 0);
            end else begin
                checkOutput("a_addr", int'(addr_a), addr_m[0]);
                checkOutput("a_on", int'(on_a), int'(exp_on[0]));
                checkOutput("a_valid", int'(valid_a), int'(exp_valid[0]));
                checkOutput("b_addr", int'(addr_b), addr_m[1]);
                checkOutput("b_on", int'(on_b), int'(exp_on[1]));
                checkOutput("b_valid", int'(valid_b), int'(exp_valid[1]));
            end
        end
    end

    initial begin
        int   codes [8];
        logic on_v, val_v;
        logic [7:0]  bits8;
        logic [15:0] bits16;

        codes = '{int'(G_A), int'(G_B), int'(G_SPACE), int'(G_1),
                  int'(G_0), int'(G_UP), int'(G_DOWN), int'(G_C)};
        for (int i = 0; i < 4096; i++) mem[i] = 6'(codes[i % 8]);

        // Hand-computed values that pin the model.
        bits8 = '0;
        for (int i = 0; i < 8; i++) begin
            model_pixel(0, 2, i, 0, 3'b000, 0, on_v, val_v);
            bits8[7-i] = on_v;
        end
        checkOutput("lit_a_row0", int'(bits8), 'h18);
        checkOutput("lit_a_valid", int'(val_v), 1);
        bits16 = '0;
        for (int i = 0; i < 16; i++) begin
            model_pixel(1, 30, i, 0, 3'b000, 0, on_v, val_v);
            bits16[15-i] = on_v;
        end
        checkOutput("lit_scale2_row0", int'(bits16), 'h03C0);
        checkOutput("lit_addr_15", model_addr(1, 15, 0), 0);
        checkOutput("lit_addr_16", model_addr(1, 16, 0), 1);
        model_pixel(0, 2, 18, 0, 3'b100, 0, on_v, val_v);
        checkOutput("lit_space_inv", int'(on_v), 1);
        model_pixel(0, 2, 640, 0, 3'b100, 0, on_v, val_v);
        checkOutput("lit_edge_valid", int'(val_v), 0);
        model_pixel(0, 2, 3, 0, 3'b001, 0, on_v, val_v);
        checkOutput("lit_alarm_blank", int'(on_v), 0);
        bits8 = '0;
        for (int t = 0; t < 8; t++) begin
            model_pixel(0, 2, 3, 1, 3'b011, t, on_v, val_v);
            bits8[t] = on_v;
        end
        checkOutput("lit_blink_seq", int'(bits8), 'h33);

        // Power-on reset, then release.
        for (int i = 0; i < 3; i++) applyStimulus(700, 500, 1'b0, 8'h00, 8'h00);
        rst = 1'b0;

        // Plain glyph scan of the first line (covers both scales), then edge.
        scanLine(0, 0, 31);
        flush(4);

        // Inverse video over a space cell.
        applyStimulus(700, 0, 1'b1, 8'h00, 8'h04);
        scanLine(0, 16, 23);
        flush(4);

        // Alarm without blink blanks everything; foreign port is ignored.
        applyStimulus(700, 0, 1'b1, 8'h00, 8'h01);
        scanLine(2, 0, 15);
        applyStimulus(700, 0, 1'b1, 8'h01, 8'h04);
        scanLine(2, 0, 15);
        flush(4);

        // Reset held for three clocks in the middle of a line.
        scanLine(3, 0, 11);
        rst = 1'b1;
        scanLine(3, 12, 14);
        rst = 1'b0;
        scanLine(3, 15, 30);
        flush(4);

        // Blink with alarm: one observation per frame over eight frames.
        applyStimulus(700, 1, 1'b1, 8'h00, 8'h03);
        scanLine(1, 0, 7);
        for (int f = 1; f < 8; f++) begin
            applyStimulus(0, 0, 1'b0, 8'h00, 8'h00);
            scanLine(1, 0, 7);
        end

        // Control write landing on the frame tick.
        applyStimulus(0, 0, 1'b1, 8'h00, 8'h04);
        scanLine(1, 0, 23);
        flush(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
